// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage.
// Opcodes, FSM states and default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_NOR = 4'd3,
        OP_EQ  = 4'd4,
        OP_SUB = 4'd5,
        OP_LT  = 4'd6,
        OP_MUL = 4'd7,
        OP_DIV = 4'd8
    } op_e;

    localparam logic [3:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESULT
    } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO.
// Pointers wrap naturally; count has one extra bit.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            din_i,
    output logic [DW-1:0]            dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU.
// Queues commands, holds operands, captures results.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iCmdValid,
    output logic             oCmdReady,
    input  logic [3:0]       iCmdOp,
    input  logic [WIDTH-1:0] iCmdA,
    input  logic [WIDTH-1:0] iCmdB,
    output logic [WIDTH-1:0] oAluA,
    output logic [WIDTH-1:0] oAluB,
    output logic [3:0]       oAluCtrl,
    input  logic [WIDTH-1:0] iAluOut,
    input  logic             iAluCarry,
    output logic             oResValid,
    input  logic             iResReady,
    output logic [WIDTH-1:0] oResData,
    output logic             oResCarry,
    output logic             oResZero,
    output logic             oResErr,
    output logic [3:0]       oResOp,
    output logic             oBusy
);

    localparam int DW = 4 + 2 * WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(SETTLE + 1);

    state_e          state_q;
    logic [SW-1:0]   cnt_q;
    logic            full, empty, pop;
    logic [CW-1:0]   count;
    logic [DW-1:0]   head;
    logic [3:0]      head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic [WIDTH-1:0] cap_data;
    logic            cap_carry, cap_err;

    assign oCmdReady = !full;
    assign {head_op, head_a, head_b} = head;
    assign oBusy = (count != '0) || (state_q != IDLE);

    assign pop = !empty &&
                 ((state_q == IDLE) ||
                  (state_q == RESULT && iResReady));

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .push_i  (iCmdValid && !full),
        .pop_i   (pop),
        .din_i   ({iCmdOp, iCmdA, iCmdB}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Error cases override whatever the ALU drives.
    always_comb begin
        cap_data  = iAluOut;
        cap_carry = 1'b0;
        cap_err   = 1'b0;
        unique case (1'b1)
            (oAluCtrl > OP_LAST): begin
                cap_data = '0;
                cap_err  = 1'b1;
            end
            (oAluCtrl == OP_DIV && oAluB == '0): begin
                cap_data = '1;
                cap_err  = 1'b1;
            end
            (oAluCtrl == OP_ADD): cap_carry = iAluCarry;
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            oAluA     <= '0;
            oAluB     <= '0;
            oAluCtrl  <= '0;
            oResValid <= 1'b0;
            oResData  <= '0;
            oResCarry <= 1'b0;
            oResZero  <= 1'b0;
            oResErr   <= 1'b0;
            oResOp    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        oAluA    <= head_a;
                        oAluB    <= head_b;
                        oAluCtrl <= head_op;
                        cnt_q    <= SW'(SETTLE);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == SW'(1)) begin
                        oResData  <= cap_data;
                        oResCarry <= cap_carry;
                        oResZero  <= (cap_data == '0);
                        oResErr   <= cap_err;
                        oResOp    <= oAluCtrl;
                        oResValid <= 1'b1;
                        state_q   <= RESULT;
                    end else begin
                        cnt_q <= cnt_q - SW'(1);
                    end
                end
                RESULT: begin
                    if (iResReady) begin
                        oResValid <= 1'b0;
                        if (!empty) begin
                            oAluA    <= head_a;
                            oAluB    <= head_b;
                            oAluCtrl <= head_op;
                            cnt_q    <= SW'(SETTLE);
                            state_q  <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage.
// Reference model computes results from opcode rules.
module tb_alu_issue_stage;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iCmdValid = 1'b0;
    logic        oCmdReady;
    logic [3:0]  iCmdOp = '0;
    logic [15:0] iCmdA = '0;
    logic [15:0] iCmdB = '0;
    logic [15:0] oAluA, oAluB;
    logic [3:0]  oAluCtrl;
    logic [15:0] iAluOut;
    logic        iAluCarry;
    logic        oResValid;
    logic        iResReady = 1'b0;
    logic [15:0] oResData;
    logic        oResCarry, oResZero, oResErr;
    logic [3:0]  oResOp;
    logic        oBusy;
    logic        alu_cfrc = 1'b0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    int   nchk = 0;
    int   nerr = 0;
    int   n_acc = 0;
    cmd_t q[$];

    always #5 iClk = ~iClk;

    alu_issue_stage dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iCmdValid (iCmdValid),
        .oCmdReady (oCmdReady),
        .iCmdOp    (iCmdOp),
        .iCmdA     (iCmdA),
        .iCmdB     (iCmdB),
        .oAluA     (oAluA),
        .oAluB     (oAluB),
        .oAluCtrl  (oAluCtrl),
        .iAluOut   (iAluOut),
        .iAluCarry (iAluCarry),
        .oResValid (oResValid),
        .iResReady (iResReady),
        .oResData  (oResData),
        .oResCarry (oResCarry),
        .oResZero  (oResZero),
        .oResErr   (oResErr),
        .oResOp    (oResOp),
        .oBusy     (oBusy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ideal ALU: {carry, result}; junk for illegal opcodes.
    function automatic logic [16:0] alu_fn(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        case (op)
            4'd0: return {1'b0, a & b};
            4'd1: return {1'b0, a | b};
            4'd2: return {1'b0, a} + {1'b0, b};
            4'd3: return {1'b0, ~(a | b)};
            4'd4: return {16'd0, a == b};
            4'd5: return {1'b0, a - b};
            4'd6: return {16'd0, a < b};
            4'd7: begin
                p = a * b;
                return {1'b0, p[15:0]};
            end
            4'd8: return (b == 0) ? 17'd0 : {1'b0, a / b};
            default: return 17'h1BEEF;
        endcase
    endfunction

    always_comb begin
        logic [16:0] r;
        r = alu_fn(oAluCtrl, oAluA, oAluB);
        iAluOut = r[15:0];
        iAluCarry = (oAluCtrl == 4'd2) ? r[16] : alu_cfrc;
    end

    // Expected {op, err, zero, carry, data}.
    function automatic logic [22:0] exp_res(input cmd_t c);
        logic [16:0] r;
        logic [15:0] d;
        if (c.op > 4'd8) return {c.op, 3'b110, 16'h0000};
        if (c.op == 4'd8 && c.b == 0) return {c.op, 3'b100, 16'hFFFF};
        r = alu_fn(c.op, c.a, c.b);
        d = r[15:0];
        return {c.op, 1'b0, d == 0, (c.op == 4'd2) & r[16], d};
    endfunction

    function automatic logic [22:0] got_res();
        return {oResOp, oResErr, oResZero, oResCarry, oResData};
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15))
                                           : 4'($urandom_range(0, 8));
        c.a = 16'($urandom);
        c.b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        if ($urandom_range(0, 5) == 0) c.b = c.a;
        return c;
    endfunction

    always @(negedge iClk) begin
        if (iRst_n) begin
            if (oResValid && iResReady) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    chk("sb_res", got_res(), exp_res(q.pop_front()));
                end
                n_acc++;
            end
            if (iCmdValid && oCmdReady) q.push_back({iCmdOp, iCmdA, iCmdB});
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_cmd(input cmd_t c);
        iCmdOp = c.op;
        iCmdA  = c.a;
        iCmdB  = c.b;
    endtask

    task automatic push_cmd(input cmd_t c);
        set_cmd(c);
        iCmdValid = 1'b1;
        for (int i = 0; i < 50 && !oCmdReady; i++) tick();
        if (!oCmdReady) chk("push_timeout", 0, 1);
        tick();
        iCmdValid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30 && !oResValid; i++) tick();
        if (!oResValid) chk("res_timeout", 0, 1);
    endtask

    task automatic run_one(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        cmd_t c;
        c = '{op: op, a: a, b: b};
        iResReady = 1'b0;
        push_cmd(c);
        wait_valid();
        chk("run_res", got_res(), exp_res(c));
        iResReady = 1'b1;
        tick();
        iResReady = 1'b0;
    endtask

    initial begin
        cmd_t c, c1, c2;
        int   acc, pushed, base;
        logic r;

        repeat (3) tick();
        chk("rst_ready", oCmdReady, 1);
        chk("rst_valid", oResValid, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_alu", {oAluCtrl, oAluA, oAluB}, 0);
        chk("rst_res", got_res(), 0);
        iRst_n = 1'b1;
        tick();

        // Single ADD latency and carry/zero.
        iResReady = 1'b1;
        set_cmd('{op: 4'd2, a: 16'hFFFF, b: 16'h0001});
        iCmdValid = 1'b1;
        tick();
        iCmdValid = 1'b0;
        chk("lat_c1_valid", oResValid, 0);
        chk("lat_c1_busy", oBusy, 1);
        tick();
        chk("lat_c2_valid", oResValid, 0);
        chk("lat_c2_alu", {oAluCtrl, oAluA, oAluB}, {4'd2, 16'hFFFF, 16'h0001});
        tick();
        chk("lat_c3_valid", oResValid, 1);
        chk("lat_c3_res", got_res(), {4'd2, 3'b011, 16'h0000});
        tick();
        chk("lat_done_valid", oResValid, 0);
        chk("lat_done_busy", oBusy, 0);

        // Fill with back-pressure.
        iResReady = 1'b0;
        acc = 0;
        c = rand_cmd();
        for (int i = 0; i < 8; i++) begin
            set_cmd(c);
            iCmdValid = 1'b1;
            r = oCmdReady;
            tick();
            if (r) begin
                acc++;
                c = rand_cmd();
            end
        end
        iCmdValid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_ready", oCmdReady, 0);
        base = n_acc;
        for (int i = 0; i < 200 && n_acc - base < 5; i++) begin
            iResReady = 1'($urandom_range(0, 1));
            tick();
        end
        iResReady = 1'b0;
        chk("fill_drained", n_acc - base, 5);
        chk("fill_q_empty", q.size(), 0);

        // Error and masking cases.
        run_one(4'd8, 16'h0010, 16'h0000);
        run_one(4'hA, 16'($urandom), 16'($urandom));
        alu_cfrc = 1'b1;
        run_one(4'd5, 16'd5, 16'd3);
        alu_cfrc = 1'b0;

        // Long stall then back-to-back accept.
        c1 = '{op: 4'd1, a: 16'h1200, b: 16'h0034};
        c2 = '{op: 4'd7, a: 16'h0102, b: 16'h0003};
        push_cmd(c1);
        push_cmd(c2);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", oResValid, 1);
            chk("stall_res", got_res(), exp_res(c1));
            tick();
        end
        iResReady = 1'b1;
        tick();
        iResReady = 1'b0;
        chk("b2b_valid", oResValid, 0);
        chk("b2b_exec_alu", {oAluCtrl, oAluA, oAluB}, c2);
        tick();
        chk("b2b_res_valid", oResValid, 1);
        chk("b2b_res", got_res(), exp_res(c2));
        iResReady = 1'b1;
        tick();
        iResReady = 1'b0;

        // Async reset during EXEC with two queued.
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
        wait_valid();
        iResReady = 1'b1;
        tick();
        iResReady = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        chk("arst_valid", oResValid, 0);
        chk("arst_busy", oBusy, 0);
        chk("arst_ready", oCmdReady, 1);
        chk("arst_alu", {oAluCtrl, oAluA, oAluB}, 0);
        chk("arst_res", got_res(), 0);
        q.delete();
        #2;
        iRst_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oResValid || oBusy) acc++;
        end
        chk("arst_quiet", acc, 0);
        run_one(4'd0, 16'hF0F0, 16'h3C3C);

        // Random traffic.
        pushed = 0;
        for (int i = 0; i < 3000 && pushed < 150; i++) begin
            if (!iCmdValid && $urandom_range(0, 2) != 0) begin
                set_cmd(rand_cmd());
                iCmdValid = 1'b1;
            end
            iResReady = ($urandom_range(0, 3) != 0);
            alu_cfrc = 1'($urandom_range(0, 1));
            r = iCmdValid && oCmdReady;
            tick();
            if (r) begin
                iCmdValid = 1'b0;
                pushed++;
            end
        end
        iCmdValid = 1'b0;
        iResReady = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || oBusy); i++) tick();
        chk("rand_pushed", pushed, 150);
        chk("rand_q_empty", q.size(), 0);
        chk("rand_idle", oBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
